// File: rtl/parity_frame_tx_pkg.sv
// Shared definitions for the parity frame transmitter: state encodings,
// frame geometry helpers and the serial line idle level.
package parity_frame_tx_pkg;

    // 3-bit state encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_e;

    // Start, parity and stop bits wrap every data word
    localparam int unsigned FRAME_OVERHEAD = 3;

    // Level driven on the serial line whenever no frame is in flight
    localparam logic LINE_IDLE = 1'b1;

    // Total bits on the line per frame (FRAME_BITS = WIDTH+3)
    function automatic int unsigned frame_bits(input int unsigned width);
        return width + FRAME_OVERHEAD;
    endfunction

    // Counter width for a 0..n-1 range, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parity_frame_tx_if.sv
// Word handshake between a producer (master) and the transmitter (slave).
//   in_data  : word to transmit, sampled only at accept
//   in_valid : producer has a word
//   in_ready : transmitter can accept this cycle
interface parity_frame_tx_if #(
    parameter int unsigned WIDTH = 3
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/parity_frame_tx_even_p_gen_nbit.sv
// Combinational even-parity generator: p makes {i, p} carry an even
// number of ones.
//   i : WIDTH-bit input word
//   p : even-parity bit
module even_p_gen_nbit #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] i,
    output logic             p
);
    assign p = ^i;
endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: accepts a word over valid/ready, then shifts
// out start(0), data LSB-first, even parity and stop(1), each bit held for
// BIT_CYCLES clocks.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   bus        : word handshake (slave side)
//   tx         : registered serial line, idles high
//   busy       : registered, high from the cycle after accept through stop
//   frame_done : registered one-cycle pulse in the first idle cycle after a frame
module parity_frame_tx
    import parity_frame_tx_pkg::*;
#(
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    parity_frame_tx_if.slave    bus,
    output logic                tx,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned CNT_W = cnt_width(BIT_CYCLES);
    localparam int unsigned IDX_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_e           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH-1:0] shreg;
    logic             par_q;
    logic             ready_q;

    logic             par_c;
    logic             accept_c;
    logic             bit_wrap_c;
    logic [WIDTH-1:0] shifted_c;

    // Parity is computed on the live bus word and captured only at accept
    even_p_gen_nbit #(.WIDTH(WIDTH)) u_par (
        .i (bus.in_data),
        .p (par_c)
    );

    assign bus.in_ready = ready_q;
    assign accept_c     = bus.in_valid && ready_q;
    assign bit_wrap_c   = (bit_cnt == CNT_LAST);
    assign shifted_c    = shreg >> 1;

    // Frame sequencer: state, bit timing, shift register and line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= LINE_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            ready_q    <= 1'b1;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_q      <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Bit timer runs only while a frame is on the line
            if (state != IDLE) begin
                bit_cnt <= bit_wrap_c ? '0 : bit_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (accept_c) begin
                        shreg   <= bus.in_data;
                        par_q   <= par_c;
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        ready_q <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_wrap_c) begin
                        tx    <= shreg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_wrap_c) begin
                        if (bit_idx == IDX_LAST) begin
                            tx    <= par_q;
                            state <= PARITY;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            shreg   <= shifted_c;
                            tx      <= shifted_c[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_wrap_c) begin
                        tx    <= LINE_IDLE;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_wrap_c) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        ready_q    <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    tx      <= LINE_IDLE;
                    busy    <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx: directed and random frames
// compared cycle by cycle against a bit-list model of the frame.
module tb_parity_frame_tx;

    localparam int unsigned WIDTH      = 3;
    localparam int unsigned BIT_CYCLES = 4;
    localparam int unsigned NBITS      = WIDTH + 3;

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic busy;
    logic frame_done;

    int errors      = 0;
    int checks      = 0;
    int accepts     = 0;
    int exp_accepts = 0;

    parity_frame_tx_if #(.WIDTH(WIDTH)) bus ();

    parity_frame_tx #(
        .WIDTH      (WIDTH),
        .BIT_CYCLES (BIT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Handshake observer: counts words taken by the DUT
    always @(posedge clk) begin
        if (rst === 1'b0 && bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
            accepts++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, data LSB-first, even parity, stop
    function automatic logic [NBITS-1:0] frame_of(input logic [WIDTH-1:0] d);
        logic [NBITS-1:0] f;
        f[0] = 1'b0;
        for (int k = 0; k < int'(WIDTH); k++) f[1 + k] = d[k];
        f[WIDTH + 1] = ($countones(d) % 2) == 1;
        f[WIDTH + 2] = 1'b1;
        return f;
    endfunction

    // mode 0: plain; 1: noisy in_valid/in_data mid-frame; 2: keep in_valid high with next_d
    task automatic send_frame(input logic [WIDTH-1:0] d, input int mode, input logic [WIDTH-1:0] next_d);
        logic [NBITS-1:0] f;
        f = frame_of(d);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        chk("ready_before_accept", 32'(bus.in_ready), 32'd1);
        step();
        exp_accepts++;
        if (mode == 2) bus.in_data = next_d;
        else           bus.in_valid = 1'b0;
        for (int b = 0; b < int'(NBITS); b++) begin
            for (int c = 0; c < int'(BIT_CYCLES); c++) begin
                if (mode == 1 && c == 0 && b == 1) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = ~d;
                end
                if (mode == 1 && c == 0 && b == 2) bus.in_valid = 1'b0;
                chk($sformatf("tx d=%0h b%0d c%0d", d, b, c), 32'(tx), 32'(f[b]));
                chk($sformatf("busy b%0d c%0d", b, c), 32'(busy), 32'd1);
                chk($sformatf("ready b%0d c%0d", b, c), 32'(bus.in_ready), 32'd0);
                chk($sformatf("done b%0d c%0d", b, c), 32'(frame_done), 32'd0);
                step();
            end
        end
        chk($sformatf("end_done d=%0h", d), 32'(frame_done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_tx", 32'(tx), 32'd1);
        chk("end_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] rd;
        int               rmode;

        // Reset held two cycles with a word offered: nothing may be taken
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = WIDTH'($urandom);
        step();
        step();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("post_rst_tx", 32'(tx), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_accepts", 32'(accepts), 32'd0);
        step();

        // Directed single frames covering both parity values
        send_frame(3'b101, 0, 3'b000);
        step();
        send_frame(3'b001, 0, 3'b000);
        send_frame(3'b111, 0, 3'b000);
        step();
        send_frame(3'b000, 0, 3'b000);
        step();
        send_frame(3'b110, 0, 3'b000);
        step();

        // Back-to-back with in_valid held: one idle clock between frames
        send_frame(3'b001, 2, 3'b110);
        send_frame(3'b110, 0, 3'b000);
        step();
        chk("b2b_accepts", 32'(accepts), 32'(exp_accepts));

        // Noise on the handshake while busy must not disturb the frame
        send_frame(3'b101, 1, 3'b000);
        step();
        chk("noise_accepts", 32'(accepts), 32'(exp_accepts));

        // Reset in the middle of a data bit abandons the frame
        bus.in_data  = 3'b101;
        bus.in_valid = 1'b1;
        step();
        exp_accepts++;
        bus.in_valid = 1'b0;
        for (int k = 0; k < int'(BIT_CYCLES) + 1; k++) step();
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("after_rst_done", 32'(frame_done), 32'd0);
            chk("after_rst_tx", 32'(tx), 32'd1);
        end
        send_frame(3'b111, 0, 3'b000);
        step();

        // Random words, random idle gaps, occasional handshake noise
        for (int n = 0; n < 20; n++) begin
            rd    = WIDTH'($urandom);
            rmode = int'($urandom_range(0, 1));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
            send_frame(rd, rmode, 3'b000);
        end
        step();
        chk("total_accepts", 32'(accepts), 32'(exp_accepts));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parity_frame_tx.md
# parity_frame_tx

Serial frame transmitter that sequences an even-parity generator. It accepts WIDTH-bit words over a valid/ready handshake and computes even parity on the accepted word. It then shifts out a frame of start bit, data bits LSB-first, parity bit and stop bit, with each bit held for BIT_CYCLES clocks. It sits between a word producer and a single-wire serial link, and owns the timing of the link.

## Interface
- WIDTH, default 3: data word width; ≥1.
- BIT_CYCLES, default 4: clocks per transmitted bit; ≥1.

- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous and active-high.
- in_data  input  WIDTH  word to transmit; sampled only at accept.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept; high iff state==IDLE.
- tx  output  1  serial line, registered; idle level 1.
- busy  output  1  registered; 1 from the cycle after accept through the last stop-bit cycle.
- frame_done  output  1  registered; one-cycle pulse at frame end.

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP.
- Reset values: state=IDLE, tx=1, busy=0, frame_done=0, counters=0. in_ready is therefore 1 in the first cycle after reset.
- Accept occurs when in_valid && in_ready at a rising edge.
  - On accept, latch in_data into the shift register.
  - On accept, latch p = ^in_data, which is the even-parity bit (data plus p has an even number of ones).
  - Move to START, with tx<=0 and busy<=1.
- The bit counter counts 0..BIT_CYCLES-1. On wrap it advances to the next bit; otherwise tx is held.
- START → DATA: tx = data[0]. Index 0..WIDTH-1, shift right on each bit boundary.
- DATA (index WIDTH-1 wraps) → PARITY: tx = latched p.
- PARITY → STOP: tx = 1.
- STOP wrap → IDLE: frame_done<=1, busy<=0, tx stays 1.
- frame_done is high in exactly the first IDLE cycle after a frame; otherwise it is 0.
- in_valid while in_ready=0 is ignored. A held in_valid is not consumed twice.
- Changes to in_data after accept have no effect on the frame in flight.
- rst mid-frame: next edge gives IDLE, tx=1, busy=0, no frame_done. The partial frame is abandoned.
- rst asserted together with in_valid: nothing is accepted.

## Timing
- The frame is WIDTH+3 bits, i.e. (WIDTH+3)*BIT_CYCLES clocks of non-idle line time. For the defaults this is 24 clocks.
- Accept at edge N puts tx=0 (start) in the cycle following edge N.
- Frame spacing is fixed. Back-to-back words are separated by exactly one IDLE clock with tx=1, in addition to the full stop bit.
- frame_done coincides with in_ready=1. A word accepted on that edge starts its start bit on the next cycle.
- BIT_CYCLES=1: one clock per bit, and no counter wrap special case.
- Counter widths: bit counter $clog2(BIT_CYCLES) with a minimum of 1; data index $clog2(WIDTH) with a minimum of 1. There is no overflow beyond the terminal compare.

## Structure
- The shared package/header holds:
  - the state encodings (3-bit localparams ST_IDLE..ST_STOP);
  - the frame length constant FRAME_BITS = WIDTH+3;
  - the line idle level.
- One sub-module, even_p_gen_nbit: parameter WIDTH, input i[WIDTH-1:0], output p = ^i. It is combinational and is instantiated once on in_data.
- Everything else, meaning the FSM, counters and shift register, lives in parity_frame_tx.

## Test plan
- Reset:
  - Check tx=1, busy=0, frame_done=0 and in_ready=1 after rst.
  - Assert rst for 2 cycles with in_valid=1; nothing is accepted.
- Single frame, WIDTH=3, BIT_CYCLES=4, in_data=3'b101: tx sequence per 4-clock bit is 0,1,0,1,0,1 (parity 0). frame_done pulses once, 24 clocks after the start bit begins.
- Parity coverage:
  - 3'b001 gives 0,1,0,0,1,1.
  - 3'b111 gives 0,1,1,1,1,1.
  - 3'b000 gives 0,0,0,0,0,1.
  - 3'b110 gives 0,0,1,1,0,1.
- Back-to-back: hold in_valid=1 with 3'b001 then 3'b110.
  - The second start bit follows exactly one idle clock after the stop bit.
  - Exactly two accepts occur.
- Ignore while busy: toggle in_data and pulse in_valid mid-frame. The frame bits are unchanged and no extra accept occurs.
- Reset mid-frame: assert rst during the DATA bit of 3'b101.
  - Next cycle: tx=1, busy=0, in_ready=1, no frame_done.
  - A subsequent 3'b111 frame transmits correctly.
